fft_input_loader: RTL and testbench

Frame loader feeding the FFT core's working RAM. It accepts windowed floating-point samples over a valid/ready stream and writes them in bit-reversed address order, so the in-place butterflies can run in natural order. On an early end-of-frame it optionally zero-pads. When the frame is complete it raises `ena_fft_core` and holds it until the core signals completion. It sits between the windowing stage and the FFT core/address control in the MFCC front end.

---
 rtl/mfcc_fft_pkg.sv | 20 ++
 rtl/fft_input_loader_if.sv | 16 +
 rtl/fft_bitrev.sv | 31 +++
 rtl/fft_input_loader.sv | 128 ++++++++++++
 tb/tb_fft_input_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mfcc_fft_pkg.sv
// Shared definitions for the MFCC FFT front end (input loader, FFT core
// control, output reader).
//   - fft_state_e : loader FSM states IDLE/LOAD/PAD/RUN
//   - FP_ZERO     : IEEE-754 single +0.0, used for zero padding
//   - FFT_ADDR_WIDTH / FFT_DATA_WIDTH : default RAM address / sample widths
package mfcc_fft_pkg;

  localparam int FFT_ADDR_WIDTH = 12;
  localparam int FFT_DATA_WIDTH = 32;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    RUN  = 2'd3
  } fft_state_e;

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream into the FFT input loader (valid/ready with end-of-frame).
//   in_valid : sample present        (master -> slave)
//   in_data  : sample, DATA_WIDTH    (master -> slave)
//   in_last  : last sample of frame  (master -> slave)
//   in_ready : slave accepts sample  (slave -> master)
interface fft_input_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/fft_bitrev.sv
// Combinational bit-reversed address generator, shared by the FFT input
// loader and the output reader.
//   cnt          : natural-order index
//   stage_number : log2(N); values above ADDR_WIDTH clamp to ADDR_WIDTH
//   addr         : cnt[stage_number-1:0] reversed, upper bits zero
module fft_bitrev
  import mfcc_fft_pkg::*;
#(
  parameter int ADDR_WIDTH = FFT_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] cnt,
  input  logic [3:0]            stage_number,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] rev_full;
  int                    stages;

  // Reverse the full word, then shift the wanted bits down: bit k of cnt
  // lands at position stages-1-k, and cnt bits at or above 'stages' are
  // shifted out so the upper address bits come out zero.
  for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
    assign rev_full[i] = cnt[ADDR_WIDTH-1-i];
  end

  always_comb begin
    stages = (int'(stage_number) > ADDR_WIDTH) ? ADDR_WIDTH : int'(stage_number);
    addr   = rev_full >> (ADDR_WIDTH - stages);
  end

endmodule

// File: rtl/fft_input_loader.sv
// FFT input loader: takes windowed samples over a valid/ready stream and
// writes them to the FFT working RAM in bit-reversed order, then holds
// ena_fft_core high until the core reports fft_done.
// Optional feature macro: FFT_ZERO_PAD_EN -- an early in_last zero-fills
// the rest of the frame (PAD state). Without it in_last is ignored and a
// frame is always exactly N samples.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle pulse, begins a frame load (IDLE only)
//   stage_number    : log2(N), sampled at start
//   max_point_fft   : N-1, sampled at start
//   s_in            : sample stream (slave modport)
//   ram_we/addr/wdata : registered RAM write port
//   ena_fft_core    : high from load completion until fft_done
//   fft_done        : completion pulse from the FFT core (RUN only)
//   load_busy       : high in LOAD or PAD
module fft_input_loader
  import mfcc_fft_pkg::*;
#(
  parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            stage_number,
  input  logic [ADDR_WIDTH-1:0] max_point_fft,
  fft_input_loader_if.slave     s_in,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ena_fft_core,
  input  logic                  fft_done,
  output logic                  load_busy
);

  fft_state_e            state, state_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d;
  logic [3:0]            stage_q;
  logic [ADDR_WIDTH-1:0] max_q;
  logic                  we_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  ena_d;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] rev_addr;

  assign s_in.in_ready = (state == LOAD);
  assign load_busy     = (state == LOAD) || (state == PAD);
  assign accept        = s_in.in_valid && s_in.in_ready;

  fft_bitrev #(.ADDR_WIDTH(ADDR_WIDTH)) u_bitrev (
    .cnt          (cnt),
    .stage_number (stage_q),
    .addr         (rev_addr)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = 1'b0;
    wdata_d = DATA_WIDTH'(FP_ZERO);
    ena_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = s_in.in_data;
          cnt_d   = cnt + 1'b1;
          if (cnt == max_q)
            state_d = RUN;
`ifdef FFT_ZERO_PAD_EN
          else if (s_in.in_last)
            state_d = PAD;
`endif
        end
      end
`ifdef FFT_ZERO_PAD_EN
      PAD: begin
        we_d  = 1'b1;
        cnt_d = cnt + 1'b1;
        if (cnt == max_q)
          state_d = RUN;
      end
`endif
      RUN: begin
        // ena is registered off the RUN state so it rises the cycle after
        // the final write is visible, and clears on the fft_done edge.
        ena_d = !fft_done;
        if (fft_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stage_q      <= '0;
      max_q        <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ena_fft_core <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      ram_we       <= we_d;
      ena_fft_core <= ena_d;
      if (we_d) begin
        ram_addr  <= rev_addr;
        ram_wdata <= wdata_d;
      end
      if (state == IDLE && start) begin
        stage_q <= stage_number;
        max_q   <= max_point_fft;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  stage_number;
  logic [11:0] max_point_fft;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ena_fft_core;
  logic        fft_done;
  logic        load_busy;

  fft_input_loader_if #(.DATA_WIDTH(32)) bus ();

  fft_input_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stage_number  (stage_number),
    .max_point_fft (max_point_fft),
    .s_in          (bus),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ena_fft_core  (ena_fft_core),
    .fft_done      (fft_done),
    .load_busy     (load_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // write / handshake monitor, sampled on the falling edge
  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          hs_q[$];
  int          ena_rise = -1;
  logic        ena_prev = 1'b0;

  always @(negedge clk) begin
    if (ram_we) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_wdata);
      wc_q.push_back(cyc);
    end
    if (bus.in_valid && bus.in_ready) hs_q.push_back(cyc);
    if (ena_fft_core && !ena_prev) ena_rise = cyc;
    ena_prev = ena_fft_core;
  end

  logic [31:0] fv [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [11:0] a8 [8]  = '{12'd0, 12'd4, 12'd2, 12'd6, 12'd1, 12'd5, 12'd3, 12'd7};
  logic [11:0] a16[16] = '{12'd0, 12'd8, 12'd4, 12'd12, 12'd2, 12'd10, 12'd6, 12'd14,
                           12'd1, 12'd9, 12'd5, 12'd13, 12'd3, 12'd11, 12'd7, 12'd15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); hs_q.delete();
    ena_rise = -1;
  endtask

  task automatic do_start(input logic [3:0] st, input logic [11:0] mx);
    start = 1'b1; stage_number = st; max_point_fft = mx;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input bit gap);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    if (gap) tick();
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  // check write i of the current frame against expected addr/data
  task automatic chk_wr(input string tag, input int i, input logic [11:0] ea, input logic [31:0] ed);
    if (i < wa_q.size()) begin
      chk({tag, "_addr"}, 32'(wa_q[i]), 32'(ea));
      chk({tag, "_data"}, wd_q[i], ed);
    end else begin
      chk({tag, "_missing"}, 32'(i), 32'(wa_q.size()));
    end
  endtask

  function automatic logic [11:0] rev9(input int k);
    logic [11:0] r = '0;
    for (int b = 0; b < 9; b++) r[8-b] = k[b];
    return r;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stage_number = '0; max_point_fft = '0; fft_done = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_ram_we",   32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ena",      32'(ena_fft_core), 0);
    chk("rst_busy",     32'(load_busy), 0);
    rst = 1'b0;
    tick();

    // frame 1: N=8, back-to-back
    clear_mon();
    do_start(4'd3, 12'd7);
    chk("f1_in_ready", 32'(bus.in_ready), 1);
    chk("f1_busy", 32'(load_busy), 1);
    for (int k = 0; k < 8; k++) send(fv[k], k == 7, 1'b0);
    chk("f1_ready_after_last", 32'(bus.in_ready), 0);
    tick(); tick(); tick();
    chk("f1_nwrites", 32'(wa_q.size()), 8);
    for (int i = 0; i < 8; i++) chk_wr("f1_wr", i, a8[i], fv[i]);
    if (wc_q.size() == 8) begin
      chk("f1_consecutive", 32'(wc_q[7] - wc_q[0]), 7);
      chk("f1_ena_rise", 32'(ena_rise), 32'(wc_q[7] + 1));
    end else chk("f1_wc_size", 32'(wc_q.size()), 8);
    chk("f1_ena", 32'(ena_fft_core), 1);

    // start in RUN is ignored
    do_start(4'd3, 12'd7);
    tick();
    chk("run_start_ena", 32'(ena_fft_core), 1);
    chk("run_start_busy", 32'(load_busy), 0);
    chk("run_start_nowr", 32'(wa_q.size()), 8);
    pulse_done();
    chk("done_ena", 32'(ena_fft_core), 0);
    chk("done_ready", 32'(bus.in_ready), 0);
    tick();

    // frame 2: N=8 with in_valid gaps
    clear_mon();
    do_start(4'd3, 12'd7);
    for (int k = 0; k < 8; k++) send(fv[k], k == 7, 1'b1);
    tick(); tick();
    chk("f2_nwrites", 32'(wa_q.size()), 8);
    for (int i = 0; i < 8; i++) chk_wr("f2_wr", i, a8[i], fv[i]);
    if (hs_q.size() == 8 && wc_q.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("f2_latency", 32'(wc_q[i] - hs_q[i]), 1);
    end else chk("f2_hs_size", 32'(hs_q.size()), 8);
    chk("f2_ena", 32'(ena_fft_core), 1);
    pulse_done();
    tick();

    // frame 3: early in_last on sample 5
    clear_mon();
    do_start(4'd3, 12'd7);
    for (int k = 0; k < 5; k++) send(fv[k], k == 4, 1'b0);
    tick(); tick(); tick(); tick(); tick();
`ifdef FFT_ZERO_PAD_EN
    chk("f3_nwrites", 32'(wa_q.size()), 8);
    for (int i = 0; i < 8; i++) chk_wr("f3_wr", i, a8[i], (i < 5) ? fv[i] : 32'h0);
    if (wc_q.size() == 8) begin
      chk("f3_pad_consec", 32'(wc_q[7] - wc_q[0]), 7);
      chk("f3_ena_rise", 32'(ena_rise), 32'(wc_q[7] + 1));
    end
    chk("f3_ena", 32'(ena_fft_core), 1);
`else
    chk("f3_nwrites_early", 32'(wa_q.size()), 5);
    chk("f3_still_ready", 32'(bus.in_ready), 1);
    chk("f3_still_busy", 32'(load_busy), 1);
    chk("f3_no_ena", 32'(ena_fft_core), 0);
    for (int k = 5; k < 8; k++) send(fv[k], k == 7, 1'b0);
    tick(); tick();
    chk("f3_nwrites", 32'(wa_q.size()), 8);
    for (int i = 0; i < 8; i++) chk_wr("f3_wr", i, a8[i], fv[i]);
    chk("f3_ena", 32'(ena_fft_core), 1);
`endif
    pulse_done();
    tick();

    // frame 4: reset in the middle of an N=16 load, then reload
    do_start(4'd4, 12'd15);
    for (int k = 0; k < 3; k++) send(32'(k + 100), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(bus.in_ready), 0);
    chk("mid_rst_we",    32'(ram_we), 0);
    chk("mid_rst_addr",  32'(ram_addr), 0);
    chk("mid_rst_wdata", ram_wdata, 0);
    chk("mid_rst_ena",   32'(ena_fft_core), 0);
    chk("mid_rst_busy",  32'(load_busy), 0);
    rst = 1'b0;
    tick();
    clear_mon();
    do_start(4'd4, 12'd15);
    for (int k = 0; k < 16; k++) send(32'(k + 200), k == 15, 1'b0);
    tick(); tick();
    chk("f4_nwrites", 32'(wa_q.size()), 16);
    for (int i = 0; i < 16; i++) chk_wr("f4_wr", i, a16[i], 32'(i + 200));
    chk("f4_ena", 32'(ena_fft_core), 1);
    pulse_done();
    tick();

    // frame 5: N=512 ramp
    clear_mon();
    do_start(4'd9, 12'd511);
    for (int k = 0; k < 512; k++) send(32'(k), k == 511, 1'b0);
    tick(); tick();
    chk("f5_nwrites", 32'(wa_q.size()), 512);
    if (wa_q.size() == 512) begin
      chk("f5_s1_addr", 32'(wa_q[1]), 256);
      chk("f5_s2_addr", 32'(wa_q[2]), 128);
      chk("f5_s511_addr", 32'(wa_q[511]), 511);
    end
    for (int i = 0; i < 512; i++) chk_wr("f5_wr", i, rev9(i), 32'(i));
    chk("f5_ena", 32'(ena_fft_core), 1);
    pulse_done();
    chk("f5_done_ena", 32'(ena_fft_core), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
